// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants: control bundle bit map, bubble value, x0 index
package riscv_pipe_pkg;

    localparam int CTRL_W = 8;

    // Control bundle bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 7;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
    localparam logic [4:0]        REG_X0      = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard term between EX and ID
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    // A source only conflicts if the instruction really reads it; x0 never conflicts
    always_comb begin
        rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
        lu      = id_valid && ex_valid && ex_memread && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, WB bypass, flush and hold (optional ID_EX_PERF_CNT_EN counters)
module id_ex_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              pc_write,
    output logic              ifid_write
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`endif
);

    import riscv_pipe_pkg::*;

    logic            lu;
    logic            stall;
    logic [XLEN-1:0] rs1_byp;
    logic [XLEN-1:0] rs2_byp;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_memread  (ex_ctrl[CTRL_MEMREAD]),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .lu          (lu)
    );

    // A taken branch kills the ID instruction anyway, so it must not be held back by lu
    assign stall      = lu && !flush;
    assign pc_write   = reset || !(hold || stall);
    assign ifid_write = pc_write;

    // Register file is written at the end of this cycle; pick the WB value up now
    always_comb begin
        rs1_byp = id_rs1_data;
        rs2_byp = id_rs2_data;
        if (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == id_rs1)) begin
            rs1_byp = wb_data;
        end
        if (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == id_rs2)) begin
            rs2_byp = wb_data;
        end
    end

    // Pipeline register: reset, then hold, then bubble on flush or load-use, else capture ID
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rs1      <= REG_X0;
            ex_rs2      <= REG_X0;
            ex_rd       <= REG_X0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_ctrl     <= CTRL_W'(CTRL_BUBBLE);
        end else if (!hold) begin
            if (flush || lu) begin
                ex_valid    <= 1'b0;
                ex_rs1      <= REG_X0;
                ex_rs2      <= REG_X0;
                ex_rd       <= REG_X0;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_imm      <= '0;
                ex_pc       <= '0;
                ex_ctrl     <= CTRL_W'(CTRL_BUBBLE);
            end else begin
                ex_valid    <= id_valid;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_rs1_data <= rs1_byp;
                ex_rs2_data <= rs2_byp;
                ex_imm      <= id_imm;
                ex_pc       <= id_pc;
                ex_ctrl     <= id_ctrl;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Event counters advance only on edges where the stage is not held
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!hold) begin
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
